mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single 128-bit-block main memory between the instruction cache and the data cache.
- Sits between both cache controllers' miss/write-back memory ports and the main memory.
- Accepts level-held requests and grants one requester at a time, round-robin on ties.
- Latches the granted address/data, runs the memory handshake, and returns the block to the owner with a one-cycle completion window.

Parameters:
ADDR_W, 6, block address width
BLOCK_W, 128, block data width
TIMEOUT, 255, max GRANT cycles before abort; 0 disables watchdog

Ports:
clock  input  1  system clock, posedge
reset  input  1  asynchronous active-low reset
i_read  input  1  icache block read request, held until i_busywait low
i_address  input  ADDR_W  icache block address
i_readdata  output  BLOCK_W  block returned to icache
i_busywait  output  1  icache stall
d_read  input  1  dcache block read request
d_write  input  1  dcache block write-back request (never with d_read)
d_address  input  ADDR_W  dcache block address
d_writedata  input  BLOCK_W  dcache write-back block
d_readdata  output  BLOCK_W  block returned to dcache
d_busywait  output  1  dcache stall
mem_read  output  1  memory read strobe
mem_write  output  1  memory write strobe
mem_address  output  ADDR_W  memory block address
mem_writedata  output  BLOCK_W  memory write block
mem_readdata  input  BLOCK_W  memory read block
mem_busywait  input  1  memory busy
timeout_err  output  1  sticky watchdog flag

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, last_grant=I so the first tie goes to D.
  - mem_read, mem_write, i_busywait, d_busywait, timeout_err, wait counter all 0.
  - mem_address, mem_writedata, i_readdata, d_readdata = 0.
  - Reset mid-operation drops memory strobes immediately; the transfer is abandoned.
- Requests: i_req=i_read; d_req=d_read|d_write.
- Busywait (combinational):
  - i_busywait = i_req & !(state==DONE & owner==I).
  - d_busywait likewise for D.
  - Both are 0 when the port has no request.
- States:
  - IDLE:
    - Only one request → GRANT to it.
    - Both requesting → grant the port ≠ last_grant.
    - At the grant edge, latch address; for D also latch d_writedata and op (read/write); set owner and last_grant; clear started and the wait counter.
  - GRANT:
    - mem_read or mem_write = latched op (registered, asserted from the first GRANT cycle); mem_address/mem_writedata driven from the latches.
    - The started flag sets on the first GRANT posedge.
    - Completion is the posedge with started=1 and mem_busywait=0. On completion: load mem_readdata into the owner's readdata register (reads only; writes leave it unchanged), drop strobes → DONE.
    - The wait counter increments each GRANT cycle. When TIMEOUT≠0 and the count equals TIMEOUT: set timeout_err, drop strobes → DONE; readdata unchanged.
  - DONE (exactly 1 cycle):
    - Owner busywait=0; owner readdata is valid.
    - New requests are not sampled → IDLE.
    - The requester must deassert or change its request during this cycle. A request still held in IDLE is treated as new.
- Latency: request seen at edge N → GRANT from N.
  - With a memory busy for k≥1 cycles, completion at edge N+k+1, DONE for one cycle, next arbitration at the following edge.
  - Back-to-back service of the other port begins 2 edges after completion.
- Address/data changes on inputs during GRANT are ignored (latched).
- readdata registers hold their value until the next completed read for that port.
- Only the granted port's memory-side strobes are ever driven. mem_read and mem_write are never both 1.
- Starvation bound: with both ports continuously requesting, grants strictly alternate I/D.
- timeout_err clears only on reset.

Test Plan:
- Reset low mid-GRANT (d_read, addr 6'h15) → mem_read falls immediately; all outputs 0; state IDLE; a subsequent i_read is granted normally.
- Lone i_read addr 6'h0A; memory busy 5 cycles returning 128'hDEAD..01 → mem_read=1, mem_address=6'h0A, i_busywait low exactly one cycle with i_readdata=128'hDEAD..01; d_busywait stays 0.
- i_read and d_write (addr 6'h3F, data 128'hA5A5..) rise same cycle after reset → D served first (mem_write=1, mem_writedata latched), then I; d_readdata unchanged.
- Both ports held requesting for 6 transactions → grant order D,I,D,I,D,I; no port waits more than one other transaction.
- d_address changes from 6'h01 to 6'h02 during GRANT → mem_address stays 6'h01 throughout.
- TIMEOUT=8, mem_busywait stuck high → after 8 GRANT cycles strobes drop, timeout_err=1 and stays 1; DONE releases the requester; next request is served normally.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two cache controllers, the arbiter and main memory.
// The master modport is the arbiter's view; slave is the surrounding system's view.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W  = 6,
  parameter int unsigned BLOCK_W = 128
);
  logic               i_read;
  logic [ADDR_W-1:0]  i_address;
  logic [BLOCK_W-1:0] i_readdata;
  logic               i_busywait;

  logic               d_read;
  logic               d_write;
  logic [ADDR_W-1:0]  d_address;
  logic [BLOCK_W-1:0] d_writedata;
  logic [BLOCK_W-1:0] d_readdata;
  logic               d_busywait;

  logic               mem_read;
  logic               mem_write;
  logic [ADDR_W-1:0]  mem_address;
  logic [BLOCK_W-1:0] mem_writedata;
  logic [BLOCK_W-1:0] mem_readdata;
  logic               mem_busywait;

  logic               timeout_err;

  modport master (
    input  i_read, i_address, d_read, d_write, d_address, d_writedata,
           mem_readdata, mem_busywait,
    output i_readdata, i_busywait, d_readdata, d_busywait,
           mem_read, mem_write, mem_address, mem_writedata, timeout_err
  );

  modport slave (
    output i_read, i_address, d_read, d_write, d_address, d_writedata,
           mem_readdata, mem_busywait,
    input  i_readdata, i_busywait, d_readdata, d_busywait,
           mem_read, mem_write, mem_address, mem_writedata, timeout_err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one block-wide main memory between icache and dcache,
// with a per-transaction watchdog and a one-cycle completion window per owner.
module mem_arbiter #(
  parameter int unsigned ADDR_W  = 6,
  parameter int unsigned BLOCK_W = 128,
  parameter int unsigned TIMEOUT = 255
) (
  input logic          clock,
  input logic          reset,
  mem_arbiter_if.master bus
);
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, GRANT, DONE} state_e;
  typedef enum logic {OWN_I, OWN_D} owner_e;

  state_e             state, state_nx;
  owner_e             owner, owner_nx, last_grant, last_nx;
  logic               op_wr, op_wr_nx;
  logic               started, started_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic               rd_q, rd_nx, wr_q, wr_nx;
  logic [ADDR_W-1:0]  addr_q, addr_nx;
  logic [BLOCK_W-1:0] wdata_q, wdata_nx;
  logic [BLOCK_W-1:0] i_data_q, i_data_nx, d_data_q, d_data_nx;
  logic               terr_q, terr_nx;
  logic               i_req, d_req, grant_d;

  assign i_req = bus.i_read;
  assign d_req = bus.d_read | bus.d_write;

  // Stall is released only in the owner's single DONE cycle
  assign bus.i_busywait = i_req & ~(state == DONE && owner == OWN_I);
  assign bus.d_busywait = d_req & ~(state == DONE && owner == OWN_D);

  assign bus.mem_read      = rd_q;
  assign bus.mem_write     = wr_q;
  assign bus.mem_address   = addr_q;
  assign bus.mem_writedata = wdata_q;
  assign bus.i_readdata    = i_data_q;
  assign bus.d_readdata    = d_data_q;
  assign bus.timeout_err   = terr_q;

  always_comb begin
    state_nx   = state;
    owner_nx   = owner;
    last_nx    = last_grant;
    op_wr_nx   = op_wr;
    started_nx = started;
    cnt_nx     = cnt;
    rd_nx      = rd_q;
    wr_nx      = wr_q;
    addr_nx    = addr_q;
    wdata_nx   = wdata_q;
    i_data_nx  = i_data_q;
    d_data_nx  = d_data_q;
    terr_nx    = terr_q;
    grant_d    = 1'b0;
    unique case (state)
      IDLE: begin
        if (i_req || d_req) begin
          // On a tie the port that was not granted last wins
          grant_d    = d_req && (!i_req || last_grant == OWN_I);
          owner_nx   = grant_d ? OWN_D : OWN_I;
          last_nx    = grant_d ? OWN_D : OWN_I;
          started_nx = 1'b0;
          cnt_nx     = '0;
          if (grant_d) begin
            addr_nx  = bus.d_address;
            wdata_nx = bus.d_writedata;
            op_wr_nx = bus.d_write;
          end else begin
            addr_nx  = bus.i_address;
            op_wr_nx = 1'b0;
          end
          rd_nx    = ~op_wr_nx;
          wr_nx    = op_wr_nx;
          state_nx = GRANT;
        end
      end
      GRANT: begin
        started_nx = 1'b1;
        cnt_nx     = cnt + CNT_W'(1);
        if (started && !bus.mem_busywait) begin
          if (!op_wr) begin
            if (owner == OWN_I) i_data_nx = bus.mem_readdata;
            else                d_data_nx = bus.mem_readdata;
          end
          rd_nx    = 1'b0;
          wr_nx    = 1'b0;
          state_nx = DONE;
        end else if (TIMEOUT != 0 && cnt_nx == CNT_W'(TIMEOUT)) begin
          terr_nx  = 1'b1;
          rd_nx    = 1'b0;
          wr_nx    = 1'b0;
          state_nx = DONE;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      owner      <= OWN_I;
      last_grant <= OWN_I;
      op_wr      <= 1'b0;
      started    <= 1'b0;
      cnt        <= '0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      i_data_q   <= '0;
      d_data_q   <= '0;
      terr_q     <= 1'b0;
    end else begin
      state      <= state_nx;
      owner      <= owner_nx;
      last_grant <= last_nx;
      op_wr      <= op_wr_nx;
      started    <= started_nx;
      cnt        <= cnt_nx;
      rd_q       <= rd_nx;
      wr_q       <= wr_nx;
      addr_q     <= addr_nx;
      wdata_q    <= wdata_nx;
      i_data_q   <= i_data_nx;
      d_data_q   <= d_data_nx;
      terr_q     <= terr_nx;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: single-transaction vector table, directed
// corner sequences, then randomized traffic against a transaction-level memory model.
module tb_mem_arbiter;
  localparam int unsigned ADDR_W  = 6;
  localparam int unsigned BLOCK_W = 128;
  localparam int unsigned TMO     = 8;
  localparam logic [127:0] DEAD   = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0000_0001;
  localparam logic [127:0] PAT_A5 = {16{8'hA5}};
  localparam logic [127:0] W1     = 128'h0F1E_2D3C_4B5A_6978_8796_A5B4_C3D2_E1F0;

  typedef struct {
    bit           is_d;
    bit           wr;
    logic [5:0]   addr;
    logic [127:0] wdata;
    int           lat;
    int           exp_cycles;
    logic [127:0] exp_rdata;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;
  vec_t vecs [7];

  mem_arbiter_if #(.ADDR_W(ADDR_W), .BLOCK_W(BLOCK_W)) bus ();
  mem_arbiter #(.ADDR_W(ADDR_W), .BLOCK_W(BLOCK_W), .TIMEOUT(TMO)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  function automatic logic [127:0] pre(input int a);
    if (a == 10) return DEAD;
    return {8{16'(a) ^ 16'hC3C3}};
  endfunction

  // Memory model: busy for mem_lat posedges after the strobe appears, then ready
  logic [127:0] mem_array [64];
  bit mem_loaded = 1'b0;
  bit mem_active = 1'b0;
  int mem_lat = 0;
  int mem_cnt = 0;
  int fixed_lat = 0;

  always @(negedge clock) begin
    if (!mem_loaded) begin
      for (int a = 0; a < 64; a++) mem_array[a] = pre(a);
      mem_loaded = 1'b1;
    end
    if (bus.mem_read || bus.mem_write) begin
      if (!mem_active) begin
        mem_active = 1'b1;
        mem_cnt    = 0;
        mem_lat    = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(6, 1));
        if (bus.mem_write) mem_array[bus.mem_address] = bus.mem_writedata;
      end else begin
        mem_cnt++;
      end
      bus.mem_busywait = (mem_cnt < mem_lat);
    end else begin
      mem_active       = 1'b0;
      bus.mem_busywait = 1'b0;
    end
    bus.mem_readdata = mem_array[bus.mem_address];
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_port(input bit is_d, input int maxc, output int cyc, output bit ok);
    cyc = 0;
    ok  = 1'b0;
    while (!ok && cyc < maxc) begin
      @(negedge clock);
      cyc++;
      ok = !(is_d ? bus.d_busywait : bus.i_busywait);
    end
  endtask

  task automatic run_vec(input vec_t t, input int idx);
    int cyc;
    bit ok;
    @(negedge clock);
    fixed_lat = t.lat;
    if (t.is_d) begin
      bus.d_address   = t.addr;
      bus.d_writedata = t.wdata;
      bus.d_read      = !t.wr;
      bus.d_write     = t.wr;
    end else begin
      bus.i_address = t.addr;
      bus.i_read    = 1'b1;
    end
    cyc = 0;
    ok  = 1'b0;
    while (!ok && cyc < 40) begin
      @(negedge clock);
      cyc++;
      if (cyc == 1) begin
        chk_int($sformatf("v%0d_mem_read", idx), int'(bus.mem_read), t.wr ? 0 : 1);
        chk_int($sformatf("v%0d_mem_write", idx), int'(bus.mem_write), t.wr ? 1 : 0);
        chk($sformatf("v%0d_mem_address", idx), 128'(bus.mem_address), 128'(t.addr));
        if (t.wr) chk($sformatf("v%0d_mem_writedata", idx), bus.mem_writedata, t.wdata);
      end
      ok = !(t.is_d ? bus.d_busywait : bus.i_busywait);
    end
    chk_int($sformatf("v%0d_cycles", idx), cyc, t.exp_cycles);
    chk($sformatf("v%0d_readdata", idx), t.is_d ? bus.d_readdata : bus.i_readdata, t.exp_rdata);
    chk_int($sformatf("v%0d_other_busywait", idx),
            int'(t.is_d ? bus.i_busywait : bus.d_busywait), 0);
    bus.i_read  = 1'b0;
    bus.d_read  = 1'b0;
    bus.d_write = 1'b0;
  endtask

  initial begin
    int           cyc, n, guard, got;
    bit           ok;
    logic         bw;
    logic [127:0] shadow [64];
    bit           rq [2];
    logic [5:0]   ra [2];
    bit           rw;
    logic [127:0] rwd;
    int           waitc [2], oth [2], cool [2];
    int           ndone;

    vecs[0] = '{1'b0, 1'b0, 6'h0A, 128'h0,  5, 7, DEAD};
    vecs[1] = '{1'b1, 1'b1, 6'h3F, PAT_A5,  2, 4, 128'h0};
    vecs[2] = '{1'b1, 1'b0, 6'h3F, 128'h0,  1, 3, PAT_A5};
    vecs[3] = '{1'b0, 1'b0, 6'h3F, 128'h0,  3, 5, PAT_A5};
    vecs[4] = '{1'b1, 1'b1, 6'h01, W1,      1, 3, PAT_A5};
    vecs[5] = '{1'b0, 1'b0, 6'h01, 128'h0,  4, 6, W1};
    vecs[6] = '{1'b1, 1'b0, 6'h0A, 128'h0,  6, 8, DEAD};

    bus.i_read = 1'b0; bus.i_address = '0;
    bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_address = '0; bus.d_writedata = '0;
    reset = 1'b0;
    repeat (2) @(negedge clock);
    chk_int("rst_mem_read", int'(bus.mem_read), 0);
    chk_int("rst_mem_write", int'(bus.mem_write), 0);
    chk_int("rst_i_busywait", int'(bus.i_busywait), 0);
    chk_int("rst_d_busywait", int'(bus.d_busywait), 0);
    chk_int("rst_timeout_err", int'(bus.timeout_err), 0);
    chk("rst_mem_address", 128'(bus.mem_address), 128'h0);
    chk("rst_mem_writedata", bus.mem_writedata, 128'h0);
    chk("rst_i_readdata", bus.i_readdata, 128'h0);
    chk("rst_d_readdata", bus.d_readdata, 128'h0);
    reset = 1'b1;

    for (int v = 0; v < 7; v++) run_vec(vecs[v], v);

    // Reset asserted in the middle of a dcache read
    @(negedge clock);
    fixed_lat = 20; bus.d_address = 6'h15; bus.d_read = 1'b1;
    @(negedge clock);
    chk_int("rstmid_mem_read_before", int'(bus.mem_read), 1);
    chk("rstmid_addr_before", 128'(bus.mem_address), 128'h15);
    #2;
    bus.d_read = 1'b0;
    reset = 1'b0;
    #1;
    chk_int("rstmid_mem_read", int'(bus.mem_read), 0);
    chk_int("rstmid_mem_write", int'(bus.mem_write), 0);
    chk("rstmid_mem_address", 128'(bus.mem_address), 128'h0);
    chk("rstmid_i_readdata", bus.i_readdata, 128'h0);
    chk("rstmid_d_readdata", bus.d_readdata, 128'h0);
    chk_int("rstmid_i_busywait", int'(bus.i_busywait), 0);
    chk_int("rstmid_d_busywait", int'(bus.d_busywait), 0);
    chk_int("rstmid_timeout_err", int'(bus.timeout_err), 0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    fixed_lat = 2; bus.i_address = 6'h0A; bus.i_read = 1'b1;
    wait_port(1'b0, 40, cyc, ok);
    chk_int("post_rst_i_cycles", cyc, 4);
    chk("post_rst_i_readdata", bus.i_readdata, DEAD);
    bus.i_read = 1'b0;

    // Simultaneous requests after reset: dcache write wins, then icache
    @(negedge clock);
    fixed_lat = 2;
    bus.i_address = 6'h07; bus.i_read = 1'b1;
    bus.d_address = 6'h3F; bus.d_writedata = PAT_A5; bus.d_write = 1'b1;
    @(negedge clock);
    chk_int("tie_mem_write", int'(bus.mem_write), 1);
    chk_int("tie_mem_read", int'(bus.mem_read), 0);
    chk("tie_mem_address", 128'(bus.mem_address), 128'h3F);
    chk("tie_mem_writedata", bus.mem_writedata, PAT_A5);
    chk_int("tie_i_busywait", int'(bus.i_busywait), 1);
    wait_port(1'b1, 40, cyc, ok);
    chk_int("tie_d_cycles", cyc + 1, 4);
    bus.d_write = 1'b0;
    chk("tie_d_readdata", bus.d_readdata, 128'h0);
    wait_port(1'b0, 40, cyc, ok);
    chk_int("tie_i_cycles", cyc, 5);
    chk("tie_i_readdata", bus.i_readdata, pre(7));
    bus.i_read = 1'b0;

    // Both ports held continuously: grants alternate starting with D
    @(negedge clock);
    fixed_lat = 1;
    bus.i_address = 6'h05; bus.d_address = 6'h06;
    bus.i_read = 1'b1; bus.d_read = 1'b1;
    n = 0;
    guard = 0;
    while (n < 6 && guard < 100) begin
      @(negedge clock);
      guard++;
      if (!bus.d_busywait || !bus.i_busywait) begin
        got = int'(!bus.d_busywait);
        chk_int($sformatf("alt%0d_port_is_d", n), got, (n % 2 == 0) ? 1 : 0);
        chk($sformatf("alt%0d_data", n), (got == 1) ? bus.d_readdata : bus.i_readdata,
            (got == 1) ? pre(6) : pre(5));
        n++;
      end
    end
    chk_int("alt_count", n, 6);
    bus.i_read = 1'b0; bus.d_read = 1'b0;

    // Address input changes during GRANT must not reach memory
    @(negedge clock);
    fixed_lat = 4; bus.d_address = 6'h01; bus.d_read = 1'b1;
    cyc = 0;
    ok  = 1'b0;
    while (!ok && cyc < 40) begin
      @(negedge clock);
      cyc++;
      ok = !bus.d_busywait;
      if (!ok) begin
        chk($sformatf("hold_addr_c%0d", cyc), 128'(bus.mem_address), 128'h01);
        bus.d_address = 6'h02;
      end
    end
    chk_int("hold_cycles", cyc, 6);
    chk("hold_d_readdata", bus.d_readdata, W1);
    bus.d_read = 1'b0;

    // Memory stuck busy: watchdog aborts after TMO GRANT cycles
    @(negedge clock);
    fixed_lat = 1000; bus.i_address = 6'h02; bus.i_read = 1'b1;
    cyc = 0;
    ok  = 1'b0;
    while (!ok && cyc < 40) begin
      @(negedge clock);
      cyc++;
      ok = !bus.i_busywait;
      if (cyc == 8) begin
        chk_int("tmo_mem_read_c8", int'(bus.mem_read), 1);
        chk_int("tmo_err_c8", int'(bus.timeout_err), 0);
      end
    end
    chk_int("tmo_cycles", cyc, 9);
    chk_int("tmo_err", int'(bus.timeout_err), 1);
    chk_int("tmo_mem_read_dropped", int'(bus.mem_read), 0);
    chk("tmo_i_readdata_kept", bus.i_readdata, pre(5));
    bus.i_read = 1'b0;
    @(negedge clock);
    chk_int("tmo_err_sticky", int'(bus.timeout_err), 1);
    fixed_lat = 2; bus.i_read = 1'b1;
    wait_port(1'b0, 40, cyc, ok);
    chk_int("tmo_next_cycles", cyc, 4);
    chk("tmo_next_readdata", bus.i_readdata, pre(2));
    chk_int("tmo_err_still", int'(bus.timeout_err), 1);
    bus.i_read = 1'b0;

    // Randomized traffic from two independent cache clients
    fixed_lat = 0;
    for (int a = 0; a < 64; a++) shadow[a] = mem_array[a];
    for (int p = 0; p < 2; p++) begin
      rq[p] = 1'b0; ra[p] = '0; waitc[p] = 0; oth[p] = 0; cool[p] = 1;
    end
    rw = 1'b0;
    rwd = '0;
    ndone = 0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clock);
      chk_int("rand_strobe_excl", int'(bus.mem_read && bus.mem_write), 0);
      for (int p = 0; p < 2; p++) begin
        bw = (p == 1) ? bus.d_busywait : bus.i_busywait;
        if (!rq[p]) begin
          chk_int($sformatf("rand_idle_bw_p%0d", p), int'(bw), 0);
        end else if (!bw) begin
          if (p == 1 && rw) begin
            chk("rand_wr_mem", mem_array[ra[1]], rwd);
            shadow[ra[1]] = rwd;
          end else begin
            chk($sformatf("rand_rd_p%0d", p), (p == 1) ? bus.d_readdata : bus.i_readdata,
                shadow[ra[p]]);
          end
          chk_int($sformatf("rand_fair_p%0d", p), int'(oth[p] > 1), 0);
          if (rq[1-p]) oth[1-p]++;
          rq[p]   = 1'b0;
          cool[p] = int'($urandom_range(4, 1));
          ndone++;
          if (p == 0) bus.i_read = 1'b0;
          else begin bus.d_read = 1'b0; bus.d_write = 1'b0; end
        end else begin
          waitc[p]++;
          if (waitc[p] > 60) begin
            checks++;
            failures++;
            $display("FAIL rand_hang: port %0d still stalled after %0d cycles, required at most 60",
                     p, waitc[p]);
            rq[p] = 1'b0;
            if (p == 0) bus.i_read = 1'b0;
            else begin bus.d_read = 1'b0; bus.d_write = 1'b0; end
          end
        end
      end
      for (int p = 0; p < 2; p++) begin
        if (!rq[p]) begin
          if (cool[p] > 0) cool[p]--;
          else if ($urandom_range(1, 0) == 1) begin
            rq[p]    = 1'b1;
            ra[p]    = 6'($urandom_range(7, 0));
            oth[p]   = 0;
            waitc[p] = 0;
            if (p == 0) begin
              bus.i_address = ra[0];
              bus.i_read    = 1'b1;
            end else begin
              rw  = ($urandom_range(1, 0) == 1);
              rwd = {$urandom, $urandom, $urandom, $urandom};
              bus.d_address   = ra[1];
              bus.d_writedata = rwd;
              bus.d_read      = !rw;
              bus.d_write     = rw;
            end
          end
        end
      end
    end
    chk_int("rand_progress", int'(ndone > 100), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
